mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
- clk: input, 1 bit, the single clock; all state changes on its rising edge.
- rst: input, 1 bit, synchronous active-high reset.

REQ-002 The block SHALL have these parameters:
- MEM_LATENCY, default 1: number of ACCESS cycles (range 1..15).
- BASE_ADDR, default 1024: first legal byte address.
- MEM_BYTES, default 256: size of the data memory window.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- req_valid, in, 1: the pipeline MEM stage holds a load/store.
- req_write, in, 1: 1 = store, 0 = load.
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data.
- freeze, out, 1: stall the pipeline.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, 32: load data.
- rsp_fault, out, 1: the request was illegal.
- mem_r_en, out, 1: data-memory read enable.
- mem_w_en, out, 1: data-memory write enable.
- mem_address, out, 32: data-memory address.
- mem_wdata, out, 32: data-memory write data.
- mem_result, in, 32: data-memory read data (combinational from the memory).

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.

REQ-005 A request SHALL be legal iff all of the following hold:
- req_addr[1:0] = 0.
- req_addr >= BASE_ADDR.
- req_addr <= BASE_ADDR + MEM_BYTES - 4.
- The comparison is unsigned, 32-bit.

REQ-006 In IDLE with req_valid=1 and a legal request, the block SHALL latch addr, wdata and write, load the counter with MEM_LATENCY-1, and go to ACCESS.

REQ-007 In IDLE with req_valid=1 and an illegal request, the block SHALL set the fault flag, go to DONE and issue no memory access.

REQ-008 In IDLE with req_valid=0, the block SHALL stay in IDLE.

REQ-009 In ACCESS, mem_address SHALL equal the latched address and mem_wdata SHALL equal the latched wdata.

REQ-010 mem_r_en SHALL be 1 in every ACCESS cycle of a load, and 0 otherwise.

REQ-011 mem_w_en SHALL be 1 only in the last ACCESS cycle (counter = 0) of a store, giving exactly one write per store.

REQ-012 In ACCESS, the counter SHALL decrement every cycle while it is nonzero.

REQ-013 When the counter = 0 in ACCESS, the block SHALL perform these actions and go to DONE:
- Load: capture mem_result into rsp_rdata.
- Store: set rsp_rdata to 0.

REQ-014 In DONE, the block SHALL behave as follows:
- rsp_valid = 1 for exactly one cycle.
- rsp_fault = the fault flag.
- Next state is unconditionally IDLE; req_valid is ignored in DONE.
- The fault flag is cleared on leaving DONE.

REQ-015 freeze SHALL be combinational and equal 1 when either:
- state = ACCESS; or
- state = IDLE and req_valid = 1.

REQ-016 freeze SHALL be 0 in DONE.

REQ-017 rsp_rdata SHALL hold its value until the next capture.

REQ-018 A fault SHALL leave rsp_rdata unchanged.

REQ-019 Latency: a legal request accepted in cycle 0 SHALL produce rsp_valid in cycle MEM_LATENCY+1, with freeze high during cycles 0..MEM_LATENCY.

REQ-020 Latency: an illegal request accepted in cycle 0 SHALL produce rsp_valid with rsp_fault=1 in cycle 1, with freeze high in cycle 0 only.

REQ-021 Back-to-back requests SHALL incur one IDLE cycle between DONE and the next acceptance.

REQ-022 req_* changes during ACCESS SHALL have no effect, because the latched values are used.

Reset
REQ-023 On a rising clk edge with rst=1, the block SHALL:
- Set state to IDLE and the counter to 0.
- Clear the latched address/data/write and the fault flag.
- Set rsp_rdata = 0 and rsp_valid = 0.

REQ-024 From the cycle after reset, mem_r_en and mem_w_en SHALL be 0.

REQ-025 Reset during ACCESS SHALL abort the operation with no write and no rsp_valid.

REQ-026 rst SHALL take priority over all other inputs.

Verification
REQ-027 The bench SHALL cover these scenarios with MEM_LATENCY=1:
- Store then load: store addr=0x404, wdata=0xDEADBEEF -> mem_w_en high exactly one cycle with mem_address=0x404; then load 0x404 -> rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF, rsp_fault=0.
- Range boundaries: loads at 0x400 and 0x4FC complete normally; loads at 0x3FC and 0x500 -> rsp_fault=1 in cycle 1, with mem_r_en and mem_w_en never asserted.
- Misaligned store: store at 0x402 -> rsp_fault=1, no write; memory word 0x400 unchanged on read-back.

REQ-028 The bench SHALL cover MEM_LATENCY=3: a load shows freeze high for 4 cycles, mem_r_en high for 3 cycles, and rsp_valid in cycle 4.

REQ-029 The bench SHALL cover reset mid-store: rst asserted in the first ACCESS cycle of a store with MEM_LATENCY=3 -> no mem_w_en pulse, state IDLE, all outputs 0, and the target word unchanged.

REQ-030 The bench SHALL cover held request: req_valid kept high through DONE -> a single response, with the next acceptance only after an IDLE cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Three-state controller that turns a single pipeline MEM-stage
//               load/store into a data-memory access of MEM_LATENCY cycles.
//               Out-of-range or misaligned requests complete as a one-cycle
//               fault response and never touch the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int BASE_ADDR   = 1024,
  parameter int MEM_BYTES   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        freeze,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_result
);

  localparam logic [31:0] c_addr_lo  = 32'(BASE_ADDR);
  localparam logic [31:0] c_addr_hi  = 32'(BASE_ADDR + MEM_BYTES - 4);
  localparam logic [3:0]  c_cnt_init = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        w_legal;

  // Word-aligned and inside the data window (unsigned 32-bit compare).
  assign w_legal = (req_addr[1:0] == 2'b00) &&
                   (req_addr >= c_addr_lo) &&
                   (req_addr <= c_addr_hi);

  // Next-state and datapath logic; rsp_valid is registered on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_legal) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            write_d = req_write;
            cnt_d   = c_cnt_init;
            state_d = ST_ACCESS;
          end else begin
            fault_d = 1'b1;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = write_q ? 32'd0 : mem_result;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fault_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        fault_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Stall while accessing, or while a request is being accepted this cycle.
  assign freeze      = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && req_valid);
  // Loads read every access cycle; stores write only on the final one.
  assign mem_r_en    = (state_q == ST_ACCESS) && !write_q;
  assign mem_w_en    = (state_q == ST_ACCESS) && write_q && (cnt_q == 4'd0);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_valid   = valid_q;
  assign rsp_fault   = fault_q;
  assign rsp_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Two instances run
//               side by side (MEM_LATENCY 1 and 3) against a timestamp-based
//               transaction model and a reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid   [2];
  logic        req_write   [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic        freeze      [2];
  logic        rsp_valid   [2];
  logic [31:0] rsp_rdata   [2];
  logic        rsp_fault   [2];
  logic        mem_r_en    [2];
  logic        mem_w_en    [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_wdata   [2];
  logic [31:0] mem_result  [2];

  logic [31:0] env_mem [2][64];
  logic [31:0] ref_mem [2][64];

  int          lat [2] = '{1, 3};
  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  bit          chk_en = 0;

  bit          act     [2];
  int          t_acc   [2];
  bit          m_legal [2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  logic        obs_fr  [2];
  logic        obs_re  [2];
  logic        obs_we  [2];
  logic        obs_rv  [2];
  logic        obs_flt [2];
  logic [31:0] obs_rd  [2];
  logic [31:0] obs_ma  [2];
  logic [31:0] obs_md  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) >> 2;
    return int'(off[5:0]);
  endfunction

  function automatic bit legal_f(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v % 4 == 0) && (v >= 1024) && (v <= 1024 + 256 - 4);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_ctrl #(
      .MEM_LATENCY (g == 0 ? 1 : 3),
      .BASE_ADDR   (1024),
      .MEM_BYTES   (256)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid[g]),
      .req_write   (req_write[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .freeze      (freeze[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_fault   (rsp_fault[g]),
      .mem_r_en    (mem_r_en[g]),
      .mem_w_en    (mem_w_en[g]),
      .mem_address (mem_address[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_result  (mem_result[g])
    );
    assign mem_result[g] = env_mem[g][widx(mem_address[g])];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance model and memory.
  task automatic tick();
    logic        c_rst;
    logic        c_v  [2];
    logic        c_w  [2];
    logic [31:0] c_a  [2];
    logic [31:0] c_d  [2];
    logic        c_we [2];
    logic [31:0] c_ma [2];
    logic [31:0] c_md [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      int k;
      int dk;
      bit acc;
      bit dn;
      k   = cyc - t_acc[i];
      dk  = m_legal[i] ? lat[i] + 1 : 1;
      acc = act[i] && m_legal[i] && (k >= 1) && (k <= lat[i]);
      dn  = act[i] && (k == dk);
      obs_fr[i] = freeze[i];   obs_re[i]  = mem_r_en[i];  obs_we[i] = mem_w_en[i];
      obs_rv[i] = rsp_valid[i]; obs_flt[i] = rsp_fault[i]; obs_rd[i] = rsp_rdata[i];
      obs_ma[i] = mem_address[i]; obs_md[i] = mem_wdata[i];
      if (chk_en) begin
        chk1($sformatf("u%0d freeze", i), freeze[i], acc || (!act[i] && req_valid[i]));
        chk1($sformatf("u%0d mem_r_en", i), mem_r_en[i], acc && !m_wr[i]);
        chk1($sformatf("u%0d mem_w_en", i), mem_w_en[i], acc && m_wr[i] && (k == lat[i]));
        chk1($sformatf("u%0d rsp_valid", i), rsp_valid[i], dn);
        chk1($sformatf("u%0d rsp_fault", i), rsp_fault[i], dn && !m_legal[i]);
        chk($sformatf("u%0d rsp_rdata", i), rsp_rdata[i], m_rdata[i]);
        if (acc) begin
          chk($sformatf("u%0d mem_address", i), mem_address[i], m_addr[i]);
          chk($sformatf("u%0d mem_wdata", i), mem_wdata[i], m_wdata[i]);
        end
      end
      c_v[i] = req_valid[i]; c_w[i] = req_write[i]; c_a[i] = req_addr[i]; c_d[i] = req_wdata[i];
      c_we[i] = mem_w_en[i]; c_ma[i] = mem_address[i]; c_md[i] = mem_wdata[i];
    end
    c_rst = rst;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (c_we[i]) env_mem[i][widx(c_ma[i])] = c_md[i];
      if (c_rst) begin
        act[i]     = 1'b0;
        m_rdata[i] = 32'd0;
      end else if (act[i]) begin
        int k;
        k = cyc - t_acc[i];
        if (m_legal[i] && k == lat[i]) begin
          if (m_wr[i]) begin
            ref_mem[i][widx(m_addr[i])] = m_wdata[i];
            m_rdata[i] = 32'd0;
          end else begin
            m_rdata[i] = ref_mem[i][widx(m_addr[i])];
          end
        end
        if (k == (m_legal[i] ? lat[i] + 1 : 1)) act[i] = 1'b0;
      end else if (c_v[i]) begin
        act[i]     = 1'b1;
        t_acc[i]   = cyc;
        m_legal[i] = legal_f(c_a[i]);
        m_wr[i]    = c_w[i];
        m_addr[i]  = c_a[i];
        m_wdata[i] = c_d[i];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Issue one request on instance i and run until its response (bounded).
  task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit hold, output int rc, output int nfr, output int nre,
                     output int nwe, output logic [31:0] rd, output logic flt);
    int dk;
    dk = legal_f(a) ? lat[i] + 1 : 1;
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    rc = -1; nfr = 0; nre = 0; nwe = 0; rd = 32'd0; flt = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      nfr += int'(obs_fr[i]); nre += int'(obs_re[i]); nwe += int'(obs_we[i]);
      if (obs_rv[i]) begin
        rc = n; rd = obs_rd[i]; flt = obs_flt[i];
        break;
      end
      if (!hold) begin
        // Junk on the request lines during the access must be ignored.
        req_valid[i] = (n + 1 < dk);
        req_write[i] = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
      end
    end
    if (!hold) req_valid[i] = 1'b0;
    if (rc < 0) begin
      ntests++; nfail++;
      $display("FAIL u%0d response timeout: got none expected rsp_valid within 40 cycles", i);
    end
  endtask

  int          rc, nfr, nre, nwe;
  logic [31:0] rd;
  logic        flt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) begin
        env_mem[i][w] = 32'hA500_0000 + 32'(w) + 32'(i << 8);
        ref_mem[i][w] = env_mem[i][w];
      end
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
      act[i] = 1'b0; t_acc[i] = 0; m_legal[i] = 1'b0; m_wr[i] = 1'b0;
      m_addr[i] = 32'd0; m_wdata[i] = 32'd0; m_rdata[i] = 32'd0;
    end
    rst = 1'b1;
    @(negedge clk);
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    tick();
    chk1("reset rsp_valid", obs_rv[0], 1'b0);
    chk("reset rsp_rdata", obs_rd[1], 32'd0);
    chk1("reset freeze", obs_fr[1], 1'b0);

    // Store then load, latency 1.
    txn(0, 1'b1, 32'h404, 32'hDEADBEEF, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("store rsp cycle", 32'(rc), 32'd2);
    chk("store write pulses", 32'(nwe), 32'd1);
    chk1("store fault", flt, 1'b0);
    chk("store rdata", rd, 32'd0);
    chk("store memory word", env_mem[0][1], 32'hDEADBEEF);
    txn(0, 1'b0, 32'h404, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("load rsp cycle", 32'(rc), 32'd2);
    chk("load rdata", rd, 32'hDEADBEEF);
    chk1("load fault", flt, 1'b0);

    // Window boundaries.
    txn(0, 1'b0, 32'h400, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("low edge rdata", rd, 32'hA500_0000);
    txn(0, 1'b0, 32'h4FC, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("high edge rdata", rd, 32'hA500_003F);
    txn(0, 1'b0, 32'h3FC, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("below range rsp cycle", 32'(rc), 32'd1);
    chk1("below range fault", flt, 1'b1);
    chk("below range mem enables", 32'(nre + nwe), 32'd0);
    chk("below range freeze cycles", 32'(nfr), 32'd1);
    txn(0, 1'b0, 32'h500, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("above range rsp cycle", 32'(rc), 32'd1);
    chk1("above range fault", flt, 1'b1);
    chk("above range mem enables", 32'(nre + nwe), 32'd0);
    chk("fault keeps rdata", rd, 32'hA500_003F);

    // Misaligned store leaves memory alone.
    txn(0, 1'b1, 32'h402, 32'h5555_AAAA, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk1("misaligned fault", flt, 1'b1);
    chk("misaligned writes", 32'(nwe), 32'd0);
    txn(0, 1'b0, 32'h400, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("misaligned readback", rd, 32'hA500_0000);

    // Latency 3 load.
    txn(1, 1'b0, 32'h420, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("lat3 freeze cycles", 32'(nfr), 32'd4);
    chk("lat3 read cycles", 32'(nre), 32'd3);
    chk("lat3 rsp cycle", 32'(rc), 32'd4);
    chk("lat3 rdata", rd, 32'hA500_0108);

    // Reset in the first access cycle of a latency-3 store.
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h408; req_wdata[1] = 32'h1234_5678;
    tick();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    tick();
    chk1("abort first access no write", obs_we[1], 1'b0);
    rst = 1'b0;
    tick();
    chk1("abort freeze", obs_fr[1], 1'b0);
    chk1("abort mem_r_en", obs_re[1], 1'b0);
    chk1("abort rsp_valid", obs_rv[1], 1'b0);
    chk1("abort rsp_fault", obs_flt[1], 1'b0);
    chk("abort rsp_rdata", obs_rd[1], 32'd0);
    chk("abort mem_address", obs_ma[1], 32'd0);
    chk("abort mem_wdata", obs_md[1], 32'd0);
    nwe = int'(obs_we[1]);
    for (int n = 0; n < 4; n++) begin
      tick();
      nwe += int'(obs_we[1]) + int'(obs_rv[1]);
    end
    chk("abort stray activity", 32'(nwe), 32'd0);
    txn(1, 1'b0, 32'h408, 32'h0, 1'b0, rc, nfr, nre, nwe, rd, flt);
    chk("abort target unchanged", rd, 32'hA500_0102);

    // Request held high through DONE: one response, re-acceptance after an IDLE cycle.
    txn(0, 1'b0, 32'h410, 32'h0, 1'b1, rc, nfr, nre, nwe, rd, flt);
    chk("held rsp cycle", 32'(rc), 32'd2);
    chk("held rdata", rd, 32'hA500_0004);
    tick();
    chk1("held idle rsp_valid", obs_rv[0], 1'b0);
    chk1("held idle freeze", obs_fr[0], 1'b1);
    req_valid[0] = 1'b0;
    rc = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (obs_rv[0]) begin
        rc = n;
        break;
      end
    end
    chk("held second rsp cycle", 32'(rc), 32'd1);

    // Randomized traffic around the window on both instances.
    for (int t = 0; t < 80; t++) begin
      int          i;
      logic [31:0] a;
      i = int'($urandom_range(1, 0));
      a = 32'd1016 + 32'($urandom_range(67, 0) * 4);
      if ($urandom_range(3, 0) == 0) a = a + 32'($urandom_range(3, 0));
      txn(i, 1'($urandom), a, $urandom, 1'b0, rc, nfr, nre, nwe, rd, flt);
      if ($urandom_range(3, 0) == 0) tick();
    end

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 64; w++)
        chk($sformatf("u%0d memory word %0d", i, w), env_mem[i][w], ref_mem[i][w]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
